// File: rtl/stdp_pkg.sv
// Shared constants, FSM state type and saturating weight arithmetic for the STDP scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stdp_pkg;

    localparam int N_PRE  = 4;
    localparam int W_BITS = 4;
    localparam int T_BITS = 8;
    localparam int WINDOW = 16;
    localparam int W_INIT = 8;
    localparam int IDX_W  = $clog2(N_PRE);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    // Potentiate or depress one weight by delta, clamping at full scale and zero.
    function automatic logic [W_BITS-1:0] sat_add_sub(
        input logic [W_BITS-1:0] w,
        input logic [W_BITS:0]   delta,
        input logic              ltp
    );
        logic [W_BITS:0]   wide;
        logic [W_BITS-1:0] res;
        wide = '0;
        if (ltp) begin
            wide = {1'b0, w} + delta;
            res  = wide[W_BITS] ? '1 : wide[W_BITS-1:0];
        end else begin
            wide = {1'b0, w} - delta;
            res  = ({1'b0, w} < delta) ? '0 : wide[W_BITS-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requesting channel at or above ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; a grant is offered whenever any request is present.
module rr_arbiter
    import stdp_pkg::*;
(
    input  logic [N_PRE-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_PRE-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] cand;

    // Walk the channels starting at ptr and keep the first one that is requesting.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_PRE; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_PRE);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stdp_update_scheduler.sv
// Per-synapse STDP scheduler: spike-age timestamps, one pending LTP/LTD per synapse, shared weight writer.
// Latency: spike in cycle k -> grant k+1 -> w_upd in k+2 -> new weight visible in k+3; one update per 2 cycles.
// Backpressure: none on spikes; a channel holds one request, later requests overwrite it until granted.
module stdp_update_scheduler
    import stdp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_PRE-1:0]        pre_spike,
    input  logic                    post_spike,
    output logic [N_PRE*W_BITS-1:0] weight,
    output logic                    w_upd,
    output logic [IDX_W-1:0]        w_idx,
    output logic                    busy
);

    localparam logic [T_BITS-1:0] WIN_T  = T_BITS'(WINDOW);
    localparam logic [T_BITS-1:0] HALF_T = T_BITS'(WINDOW / 2);

    logic [T_BITS-1:0] t_pre [N_PRE];
    logic [T_BITS-1:0] t_post;
    logic [N_PRE-1:0]  pend;
    logic [N_PRE-1:0]  ltp;
    logic [T_BITS-1:0] dt [N_PRE];

    logic [N_PRE-1:0]  cap_vld;
    logic [N_PRE-1:0]  cap_ltp;
    logic [T_BITS-1:0] cap_dt [N_PRE];

    state_t            state;
    state_t            state_nxt;
    logic              load_sel;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_ltp;
    logic [T_BITS-1:0] sel_dt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [W_BITS-1:0] w_q [N_PRE];

    logic [N_PRE-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [T_BITS-1:0] gnt_dt;
    logic [W_BITS:0]   delta;

    rr_arbiter u_arb (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Spike ages: clear on own spike, otherwise count up and stick at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_post <= '1;
            for (int i = 0; i < N_PRE; i++) t_pre[i] <= '1;
        end else begin
            t_post <= post_spike ? '0 : ((&t_post) ? t_post : t_post + T_BITS'(1));
            for (int i = 0; i < N_PRE; i++)
                t_pre[i] <= pre_spike[i] ? '0 : ((&t_pre[i]) ? t_pre[i] : t_pre[i] + T_BITS'(1));
        end
    end

    // Pair each spike with the partner's pre-update age; coincident pre/post cancels.
    always_comb begin
        for (int i = 0; i < N_PRE; i++) begin
            cap_vld[i] = 1'b0;
            cap_ltp[i] = 1'b0;
            cap_dt[i]  = '0;
            if (post_spike && !pre_spike[i] && (t_pre[i] < WIN_T)) begin
                cap_vld[i] = 1'b1;
                cap_ltp[i] = 1'b1;
                cap_dt[i]  = t_pre[i];
            end else if (pre_spike[i] && !post_spike && (t_post < WIN_T)) begin
                cap_vld[i] = 1'b1;
                cap_dt[i]  = t_post;
            end
        end
    end

    // Pending request slots; a fresh capture beats the clear from the write in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            ltp  <= '0;
            for (int i = 0; i < N_PRE; i++) dt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                if (cap_vld[i]) begin
                    pend[i] <= 1'b1;
                    ltp[i]  <= cap_ltp[i];
                    dt[i]   <= cap_dt[i];
                end else if (w_upd && (sel_idx == IDX_W'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and write strobes: grant in IDLE, write in APPLY.
    always_comb begin
        state_nxt = state;
        load_sel  = 1'b0;
        w_upd     = 1'b0;
        w_idx     = '0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    load_sel  = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                w_upd     = 1'b1;
                w_idx     = sel_idx;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mux the granted channel's dt through the one-hot grant.
    always_comb begin
        gnt_dt = '0;
        for (int i = 0; i < N_PRE; i++)
            if (gnt[i]) gnt_dt = gnt_dt | dt[i];
    end

    assign delta = (sel_dt < HALF_T) ? (W_BITS+1)'(2) : (W_BITS+1)'(1);

    // Latch the granted request, then write its weight and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_idx <= '0;
            sel_ltp <= 1'b0;
            sel_dt  <= '0;
            rr_ptr  <= '0;
            for (int i = 0; i < N_PRE; i++) w_q[i] <= W_BITS'(W_INIT);
        end else begin
            if (load_sel) begin
                sel_idx <= gnt_idx;
                sel_ltp <= |(gnt & ltp);
                sel_dt  <= gnt_dt;
            end
            if (w_upd) begin
                w_q[sel_idx] <= sat_add_sub(w_q[sel_idx], delta, sel_ltp);
                rr_ptr       <= IDX_W'((int'(sel_idx) + 1) % N_PRE);
            end
        end
    end

    // Pack the weight file onto the output bus.
    always_comb begin
        for (int i = 0; i < N_PRE; i++) weight[i*W_BITS +: W_BITS] = w_q[i];
    end

    assign busy = (state != IDLE) || (|pend);

endmodule

// File: tb/tb_stdp_update_scheduler.sv
module tb_stdp_update_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pre_spike = 4'h0;
    logic        post_spike = 1'b0;
    logic [15:0] weight;
    logic        w_upd;
    logic [1:0]  w_idx;
    logic        busy;

    stdp_update_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .weight     (weight),
        .w_upd      (w_upd),
        .w_idx      (w_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  idx;
        logic [15:0] w;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: spike timestamps, pending table, single shared writer.
    int   last_pre[4];
    int   last_post;
    bit   mpend[4];
    bit   mltp[4];
    int   mdt[4];
    int   mw[4];
    int   rr;
    int   apply_at;
    int   svc;
    int   svc_dt;
    bit   svc_ltp;
    bit   exp_busy = 1'b0;
    bit   wchk = 1'b0;
    logic [15:0] wexp;

    function automatic int age(input int last, input int c);
        if (last < 0) return 255;
        return (c - last - 1 > 255) ? 255 : c - last - 1;
    endfunction

    function automatic logic [15:0] packw();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(mw[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            last_pre[i] = -1; mpend[i] = 0; mltp[i] = 0; mdt[i] = 0; mw[i] = 8;
        end
        last_post = -1; rr = 0; apply_at = -1; exp_busy = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic [3:0] p, input logic q);
        int c;
        int d;
        int ap;
        int apo;
        c = cyc;
        exp_busy = (apply_at == c) || mpend[0] || mpend[1] || mpend[2] || mpend[3];
        if (apply_at == c) begin
            d = (svc_dt < 8) ? 2 : 1;
            if (svc_ltp) mw[svc] = (mw[svc] + d > 15) ? 15 : mw[svc] + d;
            else         mw[svc] = (mw[svc] - d < 0) ? 0 : mw[svc] - d;
            sb.push_back('{cyc: c, idx: 2'(svc), w: packw()});
            mpend[svc] = 0;
            rr = (svc + 1) % 4;
            apply_at = -1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int ch;
                ch = (rr + k) % 4;
                if (apply_at < 0 && mpend[ch]) begin
                    svc = ch; svc_ltp = mltp[ch]; svc_dt = mdt[ch]; apply_at = c + 1;
                end
            end
        end
        apo = age(last_post, c);
        for (int i = 0; i < 4; i++) begin
            ap = age(last_pre[i], c);
            if (q && !p[i] && ap < 16) begin
                mpend[i] = 1; mltp[i] = 1; mdt[i] = ap;
            end else if (p[i] && !q && apo < 16) begin
                mpend[i] = 1; mltp[i] = 0; mdt[i] = apo;
            end
        end
        for (int i = 0; i < 4; i++) if (p[i]) last_pre[i] = c;
        if (q) last_post = c;
    endtask

    task automatic tick(input logic [3:0] p, input logic q, input logic r);
        @(posedge clk);
        #1;
        rst = r; pre_spike = p; post_spike = q;
        cyc++;
        if (r) model_reset();
        else   model_step(p, q);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(4'h0, 1'b0, 1'b1);
        tick(4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_state(input string nm, input logic [15:0] ew, input logic eb);
        @(negedge clk);
        n_tests++;
        if (weight !== ew || busy !== eb) begin
            n_fail++;
            $display("FAIL %s: weight=%h busy=%b, expected weight=%h busy=%b", nm, weight, busy, ew, eb);
        end
    endtask

    // Monitor: compare every DUT write against the scoreboard, and busy every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wchk) begin
                n_tests++;
                if (weight !== wexp) begin
                    n_fail++;
                    $display("FAIL weight_after_write cyc %0d: weight=%h expected %h", cyc, weight, wexp);
                end
                wchk = 0;
            end
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cyc %0d: busy=%b expected %b", cyc, busy, exp_busy);
            end
            if (w_upd === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_w_upd cyc %0d: w_idx=%0d, expected no write", cyc, w_idx);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || w_idx !== e.idx) begin
                        n_fail++;
                        $display("FAIL w_upd_slot: cyc %0d idx %0d, expected cyc %0d idx %0d", cyc, w_idx, e.cyc, e.idx);
                    end
                    wchk = 1; wexp = e.w;
                end
            end else begin
                n_tests++;
                if (w_idx !== 2'd0) begin
                    n_fail++;
                    $display("FAIL w_idx_idle cyc %0d: w_idx=%0d expected 0", cyc, w_idx);
                end
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_w_upd cyc %0d: no write, expected idx %0d at cyc %0d", cyc, sb[0].idx, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        model_reset();
        tick(4'h0, 1'b0, 1'b1);
        check_state("reset_values", 16'h8888, 1'b0);
        n_tests++;
        if (w_upd !== 1'b0) begin
            n_fail++; $display("FAIL reset_w_upd: w_upd=%b expected 0", w_upd);
        end
        tick(4'h0, 1'b0, 1'b0);
        idle(50);
        check_state("reset_hold", 16'h8888, 1'b0);

        // LTP on channel 0
        do_reset();
        tick(4'h1, 1'b0, 1'b0);
        idle(2);
        tick(4'h0, 1'b1, 1'b0);
        idle(6);
        check_state("ltp_ch0", 16'h888A, 1'b0);

        // LTD on channel 2, then out-of-window repeat
        do_reset();
        tick(4'h0, 1'b1, 1'b0);
        idle(9);
        tick(4'h4, 1'b0, 1'b0);
        idle(6);
        check_state("ltd_ch2", 16'h8788, 1'b0);
        idle(20);
        tick(4'h0, 1'b1, 1'b0);
        idle(19);
        tick(4'h4, 1'b0, 1'b0);
        idle(6);
        check_state("ltd_outside_window", 16'h8788, 1'b0);

        // Four simultaneous requests share the writer
        do_reset();
        tick(4'hF, 1'b0, 1'b0);
        idle(4);
        tick(4'h0, 1'b1, 1'b0);
        idle(12);
        check_state("arbitration_all", 16'hAAAA, 1'b0);

        // Saturation high on ch1, low on ch3
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(4'h2, 1'b0, 1'b0);
            tick(4'h0, 1'b1, 1'b0);
            idle(25);
        end
        check_state("sat_high_ch1", 16'h88F8, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(4'h0, 1'b1, 1'b0);
            tick(4'h8, 1'b0, 1'b0);
            idle(25);
        end
        check_state("sat_low_ch3", 16'h08F8, 1'b0);

        // Coincident pre+post gives no request
        tick(4'h3, 1'b0, 1'b0);
        idle(3);
        tick(4'h3, 1'b1, 1'b0);
        idle(6);
        check_state("coincidence", 16'h08F8, 1'b0);

        // Reset landing on a write cycle
        do_reset();
        tick(4'h4, 1'b0, 1'b0);
        idle(1);
        tick(4'h0, 1'b1, 1'b0);
        guard = 0;
        while (apply_at != cyc + 1 && guard < 10) begin
            idle(1);
            guard++;
        end
        n_tests++;
        if (guard >= 10) begin
            n_fail++; $display("FAIL midapply_setup: write slot not reached, expected within 10 cycles");
        end
        tick(4'h0, 1'b0, 1'b1);
        check_state("midapply_reset", 16'h8888, 1'b0);
        n_tests++;
        if (w_upd !== 1'b0) begin
            n_fail++; $display("FAIL midapply_w_upd: w_upd=%b expected 0", w_upd);
        end
        idle(30);
        check_state("midapply_after", 16'h8888, 1'b0);

        // Random spike traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [3:0] p;
            logic       q;
            for (int i = 0; i < 4; i++) p[i] = ($urandom_range(0, 7) == 0);
            q = ($urandom_range(0, 7) == 0);
            tick(p, q, 1'b0);
        end
        idle(30);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", sb.size());
        end
        n_tests++;
        if (weight !== packw()) begin
            n_fail++; $display("FAIL random_final_weight: weight=%h expected %h", weight, packw());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stdp_update_scheduler.md
Name: stdp_update_scheduler

Overview:
- Per-synapse STDP controller for a 4-pre/1-post LIF cluster.
- Timestamps pre and post spikes with saturating counters and queues one pending LTP/LTD request per synapse.
- A round-robin arbiter shares a single saturating weight-update datapath between the synapses.
- Owns the packed weight register file that drives pad outputs and the weighted input current.

Parameters:
N_PRE, 4, number of presynaptic channels
W_BITS, 4, weight width per synapse
T_BITS, 8, spike-age counter width
WINDOW, 16, STDP window in cycles (dt < WINDOW qualifies)
W_INIT, 8, reset value of every weight

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pre_spike  in  N_PRE  one-cycle spike pulses from presynaptic LIFs
post_spike  in  1  one-cycle spike pulse from postsynaptic LIF
weight  out  N_PRE*W_BITS  packed weights; channel i at [i*W_BITS +: W_BITS]
w_upd  out  1  one-cycle pulse while a weight is being written
w_idx  out  2  channel written when w_upd=1, else 0
busy  out  1  FSM not IDLE or any request pending

Behaviour:
- Reset (async, rst=1):
  - weight = all W_INIT; w_upd = 0; w_idx = 0; busy = 0.
  - Age counters = all ones ("never spiked"); pending = 0; rr_ptr = 0; state = IDLE.
- Age counters t_pre[i] and t_post:
  - Cleared on their own spike.
  - Otherwise +1 per cycle, saturating at 2^T_BITS-1.
- Request capture (uses counter values before this cycle's update):
  - post_spike=1 and pre_spike[i]=0: if t_pre[i] < WINDOW, set pend[i], ltp[i]=1, dt[i]=t_pre[i].
  - pre_spike[i]=1 and post_spike=0: if t_post < WINDOW, set pend[i], ltp[i]=0, dt[i]=t_post.
  - pre_spike[i] and post_spike in the same cycle: no request for channel i. Counters still clear.
  - New request on a channel already pending: latest overwrites ltp/dt, and the channel is still serviced once.
  - Set and clear of pend[i] in the same cycle: set wins.
- FSM states:
  - IDLE: if pend != 0, grant the first pending channel at or after rr_ptr, searching upward with wrap. Latch sel_idx, sel_ltp, sel_dt; go to APPLY. Otherwise stay in IDLE.
  - APPLY: w_upd=1, w_idx=sel_idx.
    - weight[sel_idx] += delta (LTP), saturating at 2^W_BITS-1, or -= delta (LTD), saturating at 0.
    - Clear pend[sel_idx]; rr_ptr = sel_idx+1 (mod N_PRE); return to IDLE.
- Delta: 2 if sel_dt < WINDOW/2, else 1. Width is W_BITS+1 internally, then clamped.
- Timing: spike in cycle k → pending at edge k → IDLE grant in k+1 → APPLY with w_upd in k+2 → new weight visible in k+3.
  - Throughput: one update per 2 cycles.
  - Latched sel_* are immune to overwrites during APPLY.
- Reset mid-APPLY: the write is aborted, all state returns to reset values, and no w_upd is issued.

Decomposition:
- Shared package stdp_pkg:
  - Constants N_PRE, W_BITS, T_BITS, WINDOW, W_INIT.
  - State enum {IDLE, APPLY}.
  - Function sat_add_sub(w, delta, ltp).
- One natural sub-module, rr_arbiter: N_PRE-bit request vector plus pointer in, one-hot/index grant out, purely combinational.
- Counters, capture logic, FSM and weight file stay in the top.

Test Plan:
- Reset: assert rst → weight=16'h8888, w_upd=0, busy=0; hold 50 cycles with no spikes → unchanged.
- LTP: pre_spike[0] at cycle 0, post_spike at cycle 3 (dt=3 < 8, delta 2) → w_upd with w_idx=0 at cycle 5, weight=16'h888A at cycle 6.
- LTD: post_spike at 0, pre_spike[2] at 10 (dt=10, delta 1) → weight=16'h8788. Repeat with pre at 20 (outside window) → no w_upd.
- Arbitration: pre_spike=4'hF at 0, post at 5 → w_upd at cycles 7, 9, 11, 13 with w_idx 0, 1, 2, 3; final weight=16'hAAAA; rr_ptr back to 0.
- Saturation and coincidence:
  - 8 LTP events (dt=1) on ch1 → nibble1 reaches F and stays F, no wrap.
  - 10 LTD events on ch3 → nibble3 reaches 0 and stays 0.
  - Simultaneous pre[1]+post → no request.
- Reset mid-APPLY: assert rst during a w_upd cycle → weight=16'h8888, pend=0, no further w_upd after release.
